// File: rtl/hazard_stall_ctl.sv
// rtl/hazard_stall_ctl.sv - pipeline interlock controller (optional perf counters: STALL_CTL_PERF_EN)
module hazard_stall_ctl #(
  parameter int REG_ADDR_W   = 4,
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [REG_ADDR_W-1:0] id_rs_top,
  input  logic                  id_rs_top_used,
  input  logic [REG_ADDR_W-1:0] id_rs_bot,
  input  logic                  id_rs_bot_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [1:0]            ex_reg_wen,
  input  logic                  ex_is_load,
  input  logic                  ex_is_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_stall,
  output logic                  id_ex_hold,
  output logic                  ex_mem_hold,
  output logic                  mem_timeout,
  output logic [1:0]            ctl_state
`ifdef STALL_CTL_PERF_EN
  ,
  output logic [31:0]           perf_bubble_cnt,
  output logic [31:0]           perf_wait_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_BUBBLE   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(MEM_TIMEOUT);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          stall_req;
  logic          hold_req;
  logic          timeout_set;
  logic          lu;
  logic          mw;

  // A load whose destination feeds an operand the decoded instruction actually reads
  assign lu = ex_is_load & (|ex_reg_wen) &
              ((id_rs_top_used & (id_rs_top == ex_rd)) |
               (id_rs_bot_used & (id_rs_bot == ex_rd)));
  assign mw = mem_req & ~mem_ack;

  // Saturating increment keeps a stuck count from wrapping back to a small value
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Next-state and control decode; the RUN cycle that detects a hazard is counted as the first
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_req   = 1'b0;
    hold_req    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_RUN: begin
        if (mw) begin
          hold_req = 1'b1;
          state_n  = ST_MEM_WAIT;
          cnt_n    = CNT_ONE;
        end else if (ex_is_redirect) begin
          stall_req = 1'b1;
          state_n   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          cnt_n     = (FLUSH_CYCLES > 1) ? CNT_ONE : '0;
        end else if (lu) begin
          stall_req = 1'b1;
          state_n   = (LOAD_LAT > 2) ? ST_BUBBLE : ST_RUN;
          cnt_n     = (LOAD_LAT > 2) ? CNT_ONE : '0;
        end else begin
          cnt_n = '0;
        end
      end
      ST_BUBBLE: begin
        stall_req = 1'b1;
        if (int'(cnt) + 1 >= LOAD_LAT - 1) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_FLUSH: begin
        stall_req = 1'b1;
        if (int'(cnt) + 1 >= FLUSH_CYCLES) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else if (cnt >= TIMEOUT_V) begin
          timeout_set = 1'b1;
          state_n     = ST_RUN;
          cnt_n       = '0;
        end else begin
          hold_req = 1'b1;
          cnt_n    = cnt_inc;
        end
      end
    endcase
  end

  // State, counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Pipeline controls are gated off while reset is held so no stray bubble leaks out
  assign pc_hold     = nreset & (stall_req | hold_req);
  assign if_id_hold  = nreset & (stall_req | hold_req);
  assign id_ex_stall = nreset & stall_req;
  assign id_ex_hold  = nreset & hold_req;
  assign ex_mem_hold = nreset & hold_req;
  assign ctl_state   = state;

`ifdef STALL_CTL_PERF_EN
  // Saturating counts of bubble cycles and memory wait cycles
  always_ff @(posedge clock) begin
    if (!nreset) begin
      perf_bubble_cnt <= '0;
      perf_wait_cnt   <= '0;
    end else begin
      if (id_ex_stall && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
      if (id_ex_hold && (perf_wait_cnt != 32'hFFFF_FFFF)) begin
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
